// File: rtl/risc_controller.sv
//------------------------------------------------------------------------------
// risc_controller : VeriRISC 8-phase instruction sequencer with sticky halt.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_controller (
    input  logic       i_ctrl_clk,
    input  logic       i_ctrl_rst,
    input  logic [2:0] i_ctrl_opcode,
    input  logic       i_ctrl_zero,
    output logic       o_ctrl_sel,
    output logic       o_ctrl_rd,
    output logic       o_ctrl_ld_ir,
    output logic       o_ctrl_halt,
    output logic       o_ctrl_inc_pc,
    output logic       o_ctrl_ld_ac,
    output logic       o_ctrl_ld_pc,
    output logic       o_ctrl_wr,
    output logic       o_ctrl_data_e,
    output logic [2:0] o_ctrl_phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t phase;
    logic   halted;

    logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

    // A HLT holds the counter in OP_ADDR rather than letting it advance.
    always_ff @(posedge i_ctrl_clk or posedge i_ctrl_rst) begin
        if (i_ctrl_rst) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else if (!halted) begin
            if (phase == OP_ADDR && i_ctrl_opcode == OP_HLT) begin
                halted <= 1'b1;
            end else begin
                phase <= phase_t'(phase + 3'd1);
            end
        end
    end

    always_comb begin
        is_hlt   = (i_ctrl_opcode == OP_HLT);
        is_skz   = (i_ctrl_opcode == OP_SKZ);
        is_sto   = (i_ctrl_opcode == OP_STO);
        is_jmp   = (i_ctrl_opcode == OP_JMP);
        is_aluop = (i_ctrl_opcode == OP_ADD) || (i_ctrl_opcode == OP_AND) ||
                   (i_ctrl_opcode == OP_XOR) || (i_ctrl_opcode == OP_LDA);
    end

    // The opcode is referenced only in phases 4-7 so an unknown IR during
    // fetch cannot leak onto the strobes.
    always_comb begin
        o_ctrl_sel    = 1'b0;
        o_ctrl_rd     = 1'b0;
        o_ctrl_ld_ir  = 1'b0;
        o_ctrl_halt   = 1'b0;
        o_ctrl_inc_pc = 1'b0;
        o_ctrl_ld_ac  = 1'b0;
        o_ctrl_ld_pc  = 1'b0;
        o_ctrl_wr     = 1'b0;
        o_ctrl_data_e = 1'b0;
        if (halted) begin
            o_ctrl_halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    o_ctrl_sel = 1'b1;
                end
                INST_FETCH: begin
                    o_ctrl_sel = 1'b1;
                    o_ctrl_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    o_ctrl_sel   = 1'b1;
                    o_ctrl_rd    = 1'b1;
                    o_ctrl_ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    o_ctrl_halt   = is_hlt;
                    o_ctrl_inc_pc = !is_hlt;
                end
                OP_FETCH: begin
                    o_ctrl_rd = is_aluop;
                end
                ALU_OP: begin
                    o_ctrl_rd     = is_aluop;
                    o_ctrl_inc_pc = is_skz && i_ctrl_zero;
                    o_ctrl_ld_pc  = is_jmp;
                    o_ctrl_data_e = is_sto;
                end
                STORE: begin
                    o_ctrl_rd     = is_aluop;
                    o_ctrl_ld_ac  = is_aluop;
                    o_ctrl_inc_pc = is_jmp;
                    o_ctrl_ld_pc  = is_jmp;
                    o_ctrl_wr     = is_sto;
                    o_ctrl_data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign o_ctrl_phase = phase;

endmodule

`default_nettype wire

// File: tb/tb_risc_controller.sv
//------------------------------------------------------------------------------
// tb_risc_controller : directed self-checking bench for risc_controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    logic [8:0] snap   [0:7];
    logic [2:0] snapph [0:7];

    risc_controller dut (
        .i_ctrl_clk    (clk),
        .i_ctrl_rst    (rst),
        .i_ctrl_opcode (opcode),
        .i_ctrl_zero   (zero),
        .o_ctrl_sel    (sel),
        .o_ctrl_rd     (rd),
        .o_ctrl_ld_ir  (ld_ir),
        .o_ctrl_halt   (halt),
        .o_ctrl_inc_pc (inc_pc),
        .o_ctrl_ld_ac  (ld_ac),
        .o_ctrl_ld_pc  (ld_pc),
        .o_ctrl_wr     (wr),
        .o_ctrl_data_e (data_e),
        .o_ctrl_phase  (phase)
    );

    always #5 clk = ~clk;

    // Bit order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    wire [8:0] outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

    function automatic logic [8:0] expect_outs(input int ph, input logic [2:0] op, input logic z);
        logic alu, skz, jmp, sto;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        skz = (op == 3'd1);
        jmp = (op == 3'd7);
        sto = (op == 3'd6);
        case (ph)
            0:       return 9'b100000000;
            1:       return 9'b110000000;
            2, 3:    return 9'b111000000;
            4:       return (op == 3'd0) ? 9'b000100000 : 9'b000010000;
            5:       return (op == 3'd0) ? 9'b000100000 : {1'b0, alu, 7'b0};
            6:       return (op == 3'd0) ? 9'b000100000 :
                            {1'b0, alu, 2'b00, skz & z, 1'b0, jmp, 1'b0, sto};
            default: return (op == 3'd0) ? 9'b000100000 :
                            {1'b0, alu, 2'b00, jmp, alu, jmp, sto, sto};
        endcase
    endfunction

    function automatic logic [7:0] column(input int b);
        logic [7:0] v;
        for (int p = 0; p < 8; p++) v[p] = snap[p][b];
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [2:0] op, input logic z);
        rst    = 1'b1;
        opcode = op;
        zero   = z;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        start(op, z);
        for (int p = 0; p < 8; p++) begin
            if (p > 0) tick();
            snap[p]   = outs;
            snapph[p] = phase;
        end
    endtask

    task automatic test_reset;
        start(3'd2, 1'b0);
        repeat (5) tick();
        tests++;
        if (phase !== 3'd5 || outs !== 9'b010000000) begin
            fails++;
            $display("FAIL reset_pre phase=%0d outs=%b required phase=5 outs=010000000", phase, outs);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (phase !== 3'd0 || outs !== 9'b100000000) begin
            fails++;
            $display("FAIL reset_async phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (phase !== 3'd1 || outs !== 9'b110000000) begin
            fails++;
            $display("FAIL reset_release phase=%0d outs=%b required phase=1 outs=110000000", phase, outs);
        end
    endtask

    task automatic test_hlt;
        start(3'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++;
            if (halt !== 1'b0 || phase !== 3'(i)) begin
                fails++;
                $display("FAIL hlt_pre clk=%0d halt=%b phase=%0d required halt=0 phase=%0d", i, halt, phase, i);
            end
        end
        tick();
        tests++;
        if (halt !== 1'b1 || phase !== 3'd4 || inc_pc !== 1'b0) begin
            fails++;
            $display("FAIL hlt_set halt=%b phase=%0d inc_pc=%b required 1/4/0", halt, phase, inc_pc);
        end
        repeat (20) tick();
        tests++;
        if (phase !== 3'd4 || outs !== 9'b000100000) begin
            fails++;
            $display("FAIL hlt_sticky phase=%0d outs=%b required phase=4 outs=000100000", phase, outs);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (phase !== 3'd0 || outs !== 9'b100000000) begin
            fails++;
            $display("FAIL hlt_reset phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_skz;
        for (int z = 0; z < 2; z++) begin
            run_instr(3'd1, 1'(z));
            tests++;
            if (column(4) !== ((z == 1) ? 8'b01010000 : 8'b00010000)) begin
                fails++;
                $display("FAIL skz_inc_pc zero=%0d got=%b required=%b", z, column(4),
                         (z == 1) ? 8'b01010000 : 8'b00010000);
            end
            tests++;
            if (column(2) !== 8'b00000000) begin
                fails++;
                $display("FAIL skz_ld_pc zero=%0d got=%b required=00000000", z, column(2));
            end
        end
    endtask

    task automatic test_jmp;
        run_instr(3'd7, 1'b0);
        tests++;
        if (column(2) !== 8'b11000000) begin
            fails++;
            $display("FAIL jmp_ld_pc got=%b required=11000000", column(2));
        end
        tests++;
        if (column(4) !== 8'b10010000) begin
            fails++;
            $display("FAIL jmp_inc_pc got=%b required=10010000", column(4));
        end
        tests++;
        if (column(1) !== 8'b00000000) begin
            fails++;
            $display("FAIL jmp_wr got=%b required=00000000", column(1));
        end
    endtask

    task automatic test_sto;
        run_instr(3'd6, 1'b1);
        tests++;
        if (column(0) !== 8'b11000000) begin
            fails++;
            $display("FAIL sto_data_e got=%b required=11000000", column(0));
        end
        tests++;
        if (column(1) !== 8'b10000000) begin
            fails++;
            $display("FAIL sto_wr got=%b required=10000000", column(1));
        end
        tests++;
        if (column(3) !== 8'b00000000 || column(4) !== 8'b00010000) begin
            fails++;
            $display("FAIL sto_ld_ac_inc ld_ac=%b inc_pc=%b required 00000000/00010000", column(3), column(4));
        end
    endtask

    task automatic test_aluops;
        for (int op = 2; op <= 5; op++) begin
            run_instr(3'(op), 1'b0);
            tests++;
            if (column(7) !== 8'b11101110 || column(3) !== 8'b10000000) begin
                fails++;
                $display("FAIL aluop op=%0d rd=%b ld_ac=%b required 11101110/10000000", op, column(7), column(3));
            end
        end
    endtask

    task automatic test_sweep;
        for (int op = 0; op < 8; op++) begin
            for (int z = 0; z < 2; z++) begin
                run_instr(3'(op), 1'(z));
                for (int p = 0; p < 8; p++) begin
                    tests++;
                    if (snap[p] !== expect_outs(p, 3'(op), 1'(z)) ||
                        snapph[p] !== ((op == 0 && p > 4) ? 3'd4 : 3'(p))) begin
                        fails++;
                        $display("FAIL sweep op=%0d zero=%0d ph=%0d outs=%b phase=%0d required outs=%b",
                                 op, z, p, snap[p], snapph[p], expect_outs(p, 3'(op), 1'(z)));
                    end
                end
            end
        end
    endtask

    task automatic test_x_opcode;
        rst    = 1'b1;
        opcode = 3'bxxx;
        zero   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick();
            tests++;
            if ($isunknown(outs) || phase !== 3'(p)) begin
                fails++;
                $display("FAIL x_opcode ph=%0d outs=%b phase=%0d required known outs", p, outs, phase);
            end
        end
        opcode = 3'd2;
        tick();
        tests++;
        if (phase !== 3'd4 || outs !== 9'b000010000) begin
            fails++;
            $display("FAIL x_recover phase=%0d outs=%b required phase=4 outs=000010000", phase, outs);
        end
    endtask

    initial begin
        #1;
        tests++;
        if (phase !== 3'd0 || outs !== 9'b100000000) begin
            fails++;
            $display("FAIL reset_init phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
        end
        @(negedge clk);
        test_reset();
        test_hlt();
        test_skz();
        test_jmp();
        test_sto();
        test_aluops();
        test_sweep();
        test_x_opcode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/risc_controller.md
# risc_controller

Instruction sequencer for the VeriRISC CPU, instantiated inside `topeltop` between the instruction register/accumulator and the PC, memory, and accumulator load controls. It owns the 8-phase instruction cycle counter. It decodes the current phase, the IR opcode and the ALU zero flag into the per-phase control strobes. It also generates the sticky halt reported on `o_top_halt`.

## Interface
- No parameters. The opcode encoding is fixed: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `i_ctrl_clk`  in  1  single clock; all state updates on its rising edge.
- `i_ctrl_rst`  in  1  reset; asynchronous and active-high.
- `i_ctrl_opcode`  in  3  IR[7:5]; sampled only in phases 4–7.
- `i_ctrl_zero`  in  1  accumulator == 0; used only in phase 6.
- `o_ctrl_sel`  out  1  1 = memory address from PC, 0 = from IR operand.
- `o_ctrl_rd`  out  1  memory read enable.
- `o_ctrl_ld_ir`  out  1  load instruction register.
- `o_ctrl_halt`  out  1  CPU halted (sticky).
- `o_ctrl_inc_pc`  out  1  PC increment.
- `o_ctrl_ld_ac`  out  1  load accumulator from ALU.
- `o_ctrl_ld_pc`  out  1  load PC from IR operand.
- `o_ctrl_wr`  out  1  memory write strobe.
- `o_ctrl_data_e`  out  1  drive accumulator onto the data bus.
- `o_ctrl_phase`  out  3  current phase, for debug and bench.

## Operation
- State:
  - 3-bit phase counter: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
  - 1-bit halted flag.
- Phase counter:
  - Increments by 1 each clock and wraps 7→0.
  - Frozen while halted.
- Halted flag:
  - Set on the clock edge leaving phase 4 when the opcode is HLT.
  - Once set, the counter stays at 4 until reset.
- Outputs are combinational decodes of the registered phase, the halted flag, the opcode and zero. ALUOP = ADD|AND|XOR|LDA.
  - Phase 0: sel=1; all other outputs 0.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4:
    - halt = (opcode==HLT) | halted.
    - inc_pc = (opcode!=HLT) & ~halted.
  - Phase 5: rd=ALUOP.
  - Phase 6:
    - rd=ALUOP.
    - inc_pc = SKZ & zero.
    - ld_pc = JMP.
    - data_e = STO.
  - Phase 7:
    - rd=ALUOP, ld_ac=ALUOP.
    - inc_pc = JMP, ld_pc = JMP.
    - wr = STO, data_e = STO.
- Any output not listed for a phase is 0.
- While halted: halt=1 and every other output is 0. No PC, memory or accumulator side effects occur.
- The opcode is don't-care in phases 0–3; X on `i_ctrl_opcode` there must not propagate to any output.

## Timing
- Reset:
  - Asynchronous; phase=0 and halted=0 immediately.
  - Outputs during reset: sel=1, all other outputs 0, `o_ctrl_phase`=0.
- Release: the first rising edge after reset deasserts moves the phase to 1.
- One instruction takes exactly 8 clocks. The instruction at PC enters phase 0 every 8 clocks.
- Halt latency: `o_ctrl_halt` goes high 4 clocks after the instruction's phase 0. It stays high for all later clocks.
- SKZ: inc_pc pulses in phase 6 when zero=1. Combined with the phase-4 increment, the PC advances by 2.
- JMP:
  - ld_pc is high in phases 6 and 7.
  - inc_pc is high in phase 7.
  - The PC load has priority over increment in the PC block, so the PC equals the operand.
- STO:
  - data_e is high in phases 6–7.
  - wr is high only in phase 7, so data is stable for one clock before the write.
- Reset mid-instruction (any phase, including halted) aborts immediately to the phase 0 reset values.

## Test plan
- Reset:
  - Assert rst with phase=5 and opcode=ADD → outputs immediately become sel=1, rest 0, phase 0, without waiting for a clock edge.
  - Release and apply 1 clock → phase=1, rd=1.
- HLT:
  - Opcode=0 → halt=0 through 3 clocks after release; halt=1 after the 4th clock.
  - Apply 20 more clocks → phase stays 4, halt=1, inc_pc=0.
- SKZ with zero=1, opcode=1:
  - inc_pc=1 in phase 4 and in phase 6; ld_pc=0 throughout.
  - Repeat with zero=0 → inc_pc=1 in phase 4 only.
- JMP, opcode=7: phase 6 → ld_pc=1, inc_pc=0; phase 7 → ld_pc=1, inc_pc=1; wr=0 throughout.
- STO, opcode=6: phase 6 → data_e=1, wr=0; phase 7 → data_e=1, wr=1, ld_ac=0.
- LDA/ADD/AND/XOR:
  - Phases 5–7 → rd=1; ld_ac=1 only in phase 7.
  - Sweep all 8 opcodes × 8 phases × both zero values against the decode above.
  - Opcode=X in phases 0–3 → no X on any output.
